// File: rtl/sq_iter.sv
// Sequential unsigned squarer: radix-2 shift-and-add, one partial product per cycle.
// Fixed W-cycle latency, start/done handshake, last result held until the next completion.
module sq_iter #(
  parameter int W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     operand,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   square
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [2*W-1:0]   mcand_r, mcand_s;
  logic [W-1:0]     mplier_r, mplier_s;
  logic [2*W-1:0]   acc_r, acc_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [2*W-1:0]   square_r, square_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [2*W-1:0]   sum_s;

  // Next-state and next-datapath logic for the whole FSM.
  always_comb begin
    state_s  = state_r;
    mcand_s  = mcand_r;
    mplier_s = mplier_r;
    acc_s    = acc_r;
    cnt_s    = cnt_r;
    square_s = square_r;
    busy_s   = busy_r;
    done_s   = 1'b0;
    sum_s    = mplier_r[0] ? (acc_r + mcand_r) : acc_r;

    case (state_r)
      IDLE: begin
        if (start) begin
          state_s  = RUN;
          mcand_s  = {{W{1'b0}}, operand};
          mplier_s = operand;
          acc_s    = {(2*W){1'b0}};
          cnt_s    = CW'(W);
          busy_s   = 1'b1;
        end else begin
          state_s  = IDLE;
          busy_s   = 1'b0;
        end
      end
      RUN: begin
        acc_s    = sum_s;
        mcand_s  = mcand_r << 1;
        mplier_s = mplier_r >> 1;
        cnt_s    = cnt_r - CW'(1);
        // The final partial product lands straight in the result register.
        if (cnt_r == CW'(1)) begin
          state_s  = DONE;
          square_s = sum_s;
          done_s   = 1'b1;
        end else begin
          state_s  = RUN;
        end
      end
      DONE: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      mcand_r  <= {(2*W){1'b0}};
      mplier_r <= {W{1'b0}};
      acc_r    <= {(2*W){1'b0}};
      cnt_r    <= {CW{1'b0}};
      square_r <= {(2*W){1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      mcand_r  <= mcand_s;
      mplier_r <= mplier_s;
      acc_r    <= acc_s;
      cnt_r    <= cnt_s;
      square_r <= square_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign square = square_r;

endmodule

// File: tb/tb_sq_iter.sv
// Self-checking bench for sq_iter (W=12): directed handshake cases plus a random sweep
// compared against plain integer squaring and the fixed-latency timing rules.
module tb_sq_iter;

  localparam int W   = 12;
  localparam int LAT = W;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [W-1:0]    operand;
  logic            busy;
  logic            done;
  logic [2*W-1:0]  square;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_prev = 32'd0;

  sq_iter #(.W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .operand (operand),
    .busy    (busy),
    .done    (done),
    .square  (square)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Start one op from IDLE, scramble operand afterwards, and check timing and result.
  task automatic run_op(input logic [W-1:0] op);
    int lat;
    logic [31:0] want;
    want = 32'(op) * 32'(op);
    @(negedge clk);
    start = 1'b1;
    operand = op;
    @(posedge clk);
    #1;
    start = 1'b0;
    operand = W'($urandom);
    @(negedge clk);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      check("square_held", {8'd0, square}, exp_prev);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, LAT);
    check("square", {8'd0, square}, want);
    check("busy_in_done", {31'd0, busy}, 32'd1);
    exp_prev = want;
    @(negedge clk);
    check("done_single_pulse", {31'd0, done}, 32'd0);
    check("busy_back_idle", {31'd0, busy}, 32'd0);
    check("square_after_done", {8'd0, square}, exp_prev);
  endtask

  initial begin
    int ndone;
    int last_c;
    int gap;
    logic [W-1:0] r;

    rst_n = 1'b0;
    start = 1'b0;
    operand = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_square", {8'd0, square}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_no_done", {31'd0, done}, 32'd0);
    end

    run_op(12'd0);
    run_op(12'd1);
    run_op(12'd45);
    run_op(12'd31);
    run_op(12'd4095);
    check("max_square_hex", exp_prev, 32'h00FF_E001);

    // Second start while busy must be dropped.
    @(negedge clk);
    start = 1'b1;
    operand = 12'd100;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 3) begin
        start = 1'b1;
        operand = 12'd7;
      end else if (i == 4) begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        ndone++;
        check("busy_start_square", {8'd0, square}, 32'd10000);
      end
    end
    check("busy_start_done_count", ndone, 1);
    exp_prev = 32'd10000;

    // Continuous start: back-to-back ops every W+2 cycles.
    @(negedge clk);
    start = 1'b1;
    operand = 12'd3;
    ndone = 0;
    last_c = -1;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        check("hold_square", {8'd0, square}, 32'd9);
        if (last_c >= 0) check("hold_period", c - last_c, W + 2);
        last_c = c;
      end
    end
    check("hold_done_count_ge4", {31'd0, (ndone >= 4)}, 32'd1);
    start = 1'b0;
    repeat (20) @(negedge clk);
    exp_prev = 32'd9;

    // Reset in the middle of a computation.
    start = 1'b1;
    operand = 12'd2000;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_square", {8'd0, square}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_prev = 32'd0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    run_op(12'd2000);

    // Random sweep with random idle gaps; square must hold between completions.
    for (int k = 0; k < 1000; k++) begin
      gap = $urandom_range(3, 0);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check("gap_square_held", {8'd0, square}, exp_prev);
      end
      r = W'($urandom);
      run_op(r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
